dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//   Shares the single-port data memory (Dmem) between the RISC-V core load/store port and a debug/loader port.
//   The debug port is used by the bench and boot loader to preload and inspect memory.
//   Registered FSM: arbitrates, issues one access to a synchronous SRAM (1-cycle read latency), returns data with a ready pulse.
//   The core holds its request while stalled on cpu_ready.
// PARAMETERS
//   ADDR_W     8   word-address width of Dmem (DEPTH = 2**ADDR_W words)
//   STARVE_MAX 4   consecutive CPU grants allowed while dbg_req is pending, then debug is granted (1..15)
// PORTS
//   clk        in   1       clock, all logic on rising edge
//   rst        in   1       synchronous reset, active-high
//   cpu_req    in   1       core access request, held until cpu_ready
//   cpu_we     in   1       1 = store, 0 = load
//   cpu_be     in   4       byte enables for stores (ignored on loads)
//   cpu_addr   in   32      byte address
//   cpu_wdata  in   32      store data
//   cpu_ready  out  1       one-cycle completion pulse
//   cpu_rdata  out  32      load data, valid only while cpu_ready=1
//   cpu_err    out  1       pulses with cpu_ready when the address is out of range
//   dbg_req, dbg_we, dbg_be, dbg_addr, dbg_wdata   in   1/1/4/32/32   debug port, same semantics as cpu_*
//   dbg_ready, dbg_rdata, dbg_err                  out  1/32/1       debug port, same semantics as cpu_*
//   mem_en     out  1       SRAM enable (registered)
//   mem_we     out  1       SRAM write (registered)
//   mem_be     out  4       SRAM byte enables (registered)
//   mem_addr   out  ADDR_W  SRAM word address = addr[ADDR_W+1:2] (registered)
//   mem_wdata  out  32      SRAM write data (registered)
//   mem_rdata  in   32      SRAM read data, valid the cycle after mem_en with mem_we=0
// BEHAVIOUR
//   Reset values: all outputs 0; FSM=IDLE; starve_cnt=0; last-grant register = CPU.
//   FSM:
//   - IDLE: if any req, choose a winner, latch its request fields, go to ISSUE. Otherwise stay.
//   - ISSUE: drive mem_* from latched fields for exactly 1 cycle. Go to RESP.
//   - RESP: winner's ready=1 for 1 cycle. Go to IDLE.
//   Latency and throughput:
//   - Request sampled at edge N; mem_en is high in cycle N+1; ready is high in cycle N+2.
//   - One access per 3 cycles; the mandatory IDLE bubble is the re-arbitration point.
//   Winner selection in IDLE:
//   - Only one requester: it wins.
//   - Both requesting: CPU wins unless starve_cnt==STARVE_MAX, in which case debug wins.
//   starve_cnt:
//   - Increments on each CPU grant made while dbg_req=1.
//   - Clears on a debug grant, or on any IDLE cycle where dbg_req=0.
//   - Saturates at STARVE_MAX.
//   Read data:
//   - Loads: rdata = mem_rdata, passed combinationally while ready=1; 0 otherwise.
//   - Stores: rdata = 0.
//   Range check:
//   - If addr[31:ADDR_W+2] != 0, mem_en stays 0 in ISSUE; ready still pulses in RESP with err=1 and rdata=0.
//   - No partial access is performed.
//   - addr[1:0] is ignored; alignment is the requester's job, and be selects the bytes.
//   Ordering and hazards:
//   - Requester fields are latched in IDLE; changes after the grant do not affect the current access.
//   - A requester deasserting req before ready: the access still completes and the ready pulse is still emitted.
//   - The non-winning requester sees ready=0 and must keep req high; it is never dropped.
//   Exclusivity:
//   - Never both readies in the same cycle. Never mem_en outside ISSUE.
//   Reset mid-operation (any state): next cycle FSM=IDLE, all outputs 0, starve_cnt=0; an in-flight write may or may not have committed.
// TESTING
//   1. Debug-port preload:
//      - Write Dmem[0]=42, then read it back; the CPU port is idle.
//      - Expect dbg_ready at N+2 each time and dbg_rdata=42.
//   2. CPU store/load:
//      - cpu store 0xDEADBEEF at byte addr 12 with be=4'hF; then a load with be=4'h0.
//      - Expect mem_addr=3, cpu_rdata=0xDEADBEEF.
//      - Then a byte store of 0x11 with be=4'b0001; expect the readback 0xDEADBE11.
//   3. Simultaneous requests, STARVE_MAX=4:
//      - cpu_req and dbg_req held high.
//      - Expect the grant sequence CPU,CPU,CPU,CPU,DBG,CPU...; the debug wait never exceeds 4 CPU accesses.
//   4. Out of range:
//      - cpu load from addr 0x400 with ADDR_W=8.
//      - Expect mem_en=0 throughout, cpu_ready=1 with cpu_err=1 and cpu_rdata=0.
//      - Memory contents are unchanged.
//   5. Reset mid-access:
//      - Assert rst during ISSUE of a dbg write.
//      - Expect all outputs 0 next cycle and FSM=IDLE.
//      - A following cpu_req completes with normal 2-cycle latency.
//   6. Golden program run:
//      - Preload the program's data via the debug port, then release the core.
//      - After completion, every Dmem word read back via the debug port matches golden_output.txt.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one synchronous single-port SRAM between the core
// load/store port and the debug/loader port, one access every three cycles.

package dmem_arbiter_pkg;
    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_e;
endpackage

module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [3:0]        cpu_be,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_ready,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_err,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [3:0]        dbg_be,
    input  logic [31:0]       dbg_addr,
    input  logic [31:0]       dbg_wdata,
    output logic              dbg_ready,
    output logic [31:0]       dbg_rdata,
    output logic              dbg_err,

    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned CNT_W = 4;

    arb_state_e         state_q, state_d;
    logic [CNT_W-1:0]   starve_q, starve_d;
    logic               grant_dbg_q, grant_dbg_d;
    logic               oor_q, oor_d;
    logic               load_q, load_d;

    logic               mem_en_q, mem_en_d;
    logic               mem_we_q, mem_we_d;
    logic [3:0]         mem_be_q, mem_be_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;

    logic               cpu_ready_q, cpu_ready_d;
    logic               cpu_err_q, cpu_err_d;
    logic               dbg_ready_q, dbg_ready_d;
    logic               dbg_err_q, dbg_err_d;

    mem_req_t           cpu_req_s;
    mem_req_t           dbg_req_s;
    mem_req_t           win_s;
    logic               any_req;
    logic               pick_dbg;
    logic               win_oor;
    logic [1:0]         unused_addr_lsb;

    assign cpu_req_s = '{we: cpu_we, be: cpu_be, addr: cpu_addr, wdata: cpu_wdata};
    assign dbg_req_s = '{we: dbg_we, be: dbg_be, addr: dbg_addr, wdata: dbg_wdata};

    // Debug wins only when alone or once the CPU has used up its starvation allowance.
    assign any_req  = cpu_req | dbg_req;
    assign pick_dbg = dbg_req & (~cpu_req | (starve_q == CNT_W'(STARVE_MAX)));
    assign win_s    = pick_dbg ? dbg_req_s : cpu_req_s;
    assign win_oor  = |win_s.addr[31:ADDR_W+2];

    // Byte lanes come from be; the low address bits carry no information here.
    assign unused_addr_lsb = win_s.addr[1:0];

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        grant_dbg_d = grant_dbg_q;
        oor_d       = oor_q;
        load_d      = load_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_be_d    = 4'h0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        cpu_ready_d = 1'b0;
        cpu_err_d   = 1'b0;
        dbg_ready_d = 1'b0;
        dbg_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!dbg_req) begin
                    starve_d = '0;
                end
                if (any_req) begin
                    grant_dbg_d = pick_dbg;
                    oor_d       = win_oor;
                    load_d      = ~win_s.we & ~win_oor;
                    if (pick_dbg) begin
                        starve_d = '0;
                    end else if (dbg_req && (starve_q != CNT_W'(STARVE_MAX))) begin
                        starve_d = starve_q + CNT_W'(1);
                    end
                    // The SRAM command registers double as the latched request fields.
                    if (!win_oor) begin
                        mem_en_d    = 1'b1;
                        mem_we_d    = win_s.we;
                        mem_be_d    = win_s.be;
                        mem_addr_d  = win_s.addr[ADDR_W+1:2];
                        mem_wdata_d = win_s.wdata;
                    end
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cpu_ready_d = ~grant_dbg_q;
                cpu_err_d   = ~grant_dbg_q & oor_q;
                dbg_ready_d = grant_dbg_q;
                dbg_err_d   = grant_dbg_q & oor_q;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                oor_d   = 1'b0;
                load_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            starve_q    <= '0;
            grant_dbg_q <= 1'b0;
            oor_q       <= 1'b0;
            load_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'h0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_ready_q <= 1'b0;
            cpu_err_q   <= 1'b0;
            dbg_ready_q <= 1'b0;
            dbg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            grant_dbg_q <= grant_dbg_d;
            oor_q       <= oor_d;
            load_q      <= load_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_err_q   <= cpu_err_d;
            dbg_ready_q <= dbg_ready_d;
            dbg_err_q   <= dbg_err_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    assign cpu_ready = cpu_ready_q;
    assign cpu_err   = cpu_err_q;
    assign dbg_ready = dbg_ready_q;
    assign dbg_err   = dbg_err_q;

    // SRAM read data is only meaningful in the response cycle of an in-range load.
    assign cpu_rdata = (cpu_ready_q && load_q) ? mem_rdata : '0;
    assign dbg_rdata = (dbg_ready_q && load_q) ? mem_rdata : '0;

endmodule
